// File: rtl/cool_heat_pkg.sv
// Shared definitions for the cool/heat controller blocks: FSM encoding and
// the helper that sizes count/threshold fields.
package cool_heat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_e;

  // Bits needed to hold a count from 0 up to and including w.
  function automatic int calc_cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_popcount_hyst_popcount_chunk.sv
// Combinational ones-counter for one CHUNK-bit slice of the sensor vector.
module popcount_chunk #(
  parameter int CHUNK = 4,
  parameter int PW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits_i,
  output logic [PW-1:0]    ones_o
);

  // Sum the individual bits of the slice.
  always_comb begin
    ones_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      ones_o = ones_o + PW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/seq_popcount_hyst.sv
// Multi-cycle ones-counter with valid/ready handshake and a hysteresis
// "active" flag driven by runtime high/low thresholds.
module seq_popcount_hyst
  import cool_heat_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CW    = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [CW-1:0]    th_hi,
  input  logic [CW-1:0]    th_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             active,
  output logic             above_hi,
  output logic             below_lo
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(CHUNK + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  pc_state_e        state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    acc_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    count_q;
  logic             out_valid_q;
  logic             active_q;
  logic             above_hi_q;
  logic             below_lo_q;

  logic [PW-1:0]    chunk_ones;
  logic [CW-1:0]    sum_d;

  popcount_chunk #(
    .CHUNK (CHUNK),
    .PW    (PW)
  ) u_chunk (
    .bits_i (sh_q[CHUNK-1:0]),
    .ones_o (chunk_ones)
  );

  // Running total including the slice being counted this cycle.
  assign sum_d = acc_q + CW'(chunk_ones);

  // FSM, datapath and registered result/flags in one sequential block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      active_q    <= 1'b0;
      above_hi_q  <= 1'b0;
      below_lo_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_q    <= data;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= sum_d;
          sh_q  <= sh_q >> CHUNK;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            count_q     <= sum_d;
            above_hi_q  <= (sum_d >= th_hi);
            below_lo_q  <= (sum_d <= th_lo);
            // High threshold wins when the two overlap.
            if (sum_d >= th_hi) begin
              active_q <= 1'b1;
            end else if (sum_d <= th_lo) begin
              active_q <= 1'b0;
            end
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state so it reads 1 during reset.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign active    = active_q;
  assign above_hi  = above_hi_q;
  assign below_lo  = below_lo_q;

endmodule

// File: tb/tb_seq_popcount_hyst.sv
// Directed bench for seq_popcount_hyst (WIDTH=16, CHUNK=4).
module tb_seq_popcount_hyst;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int CW    = 5;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] data = '0;
  logic [CW-1:0]    th_hi = '0;
  logic [CW-1:0]    th_lo = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;
  logic             active;
  logic             above_hi;
  logic             below_lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] d;
    logic [4:0]  hi;
    logic [4:0]  lo;
    logic [4:0]  cnt;
    logic        act;
    logic        ab;
    logic        be;
  } vec_t;

  vec_t vecs[12];

  seq_popcount_hyst #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .th_hi     (th_hi),
    .th_lo     (th_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .active    (active),
    .above_hi  (above_hi),
    .below_lo  (below_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer one vector from a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [15:0] d, input logic [4:0] hi, input logic [4:0] lo);
    @(negedge clk);
    chk("in_ready_before_accept", int'(in_ready), 1);
    data     = d;
    th_hi    = hi;
    th_lo    = lo;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    data     = 16'h5A5A;
  endtask

  // Wait (bounded) for the result and compare it; called at the negedge after accept.
  task automatic collect(input string name, input logic [4:0] cnt, input logic act,
                         input logic ab, input logic be);
    int lat;
    lat = -1;
    chk({name, "_busy"}, int'(in_ready), 0);
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk({name, "_latency"}, lat, N);
    chk({name, "_count"}, int'(count), int'(cnt));
    chk({name, "_active"}, int'(active), int'(act));
    chk({name, "_above_hi"}, int'(above_hi), int'(ab));
    chk({name, "_below_lo"}, int'(below_lo), int'(be));
    $display("txn %s: count=%0d active=%0d above_hi=%0d below_lo=%0d latency=%0d",
             name, count, active, above_hi, below_lo, lat);
  endtask

  // Consume the pending result and confirm the block returns to IDLE.
  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_out_valid_clr"}, int'(out_valid), 0);
    chk({name, "_in_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    vecs[0]  = '{16'hFFFF, 5'd10, 5'd4,  5'd16, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{16'h00F0, 5'd10, 5'd4,  5'd4,  1'b0, 1'b0, 1'b1};
    vecs[2]  = '{16'h0FF0, 5'd10, 5'd4,  5'd8,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'hFFFF, 5'd10, 5'd4,  5'd16, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{16'h0FF0, 5'd10, 5'd4,  5'd8,  1'b1, 1'b0, 1'b0};
    vecs[5]  = '{16'h0000, 5'd10, 5'd4,  5'd0,  1'b0, 1'b0, 1'b1};
    vecs[6]  = '{16'h03FF, 5'd8,  5'd12, 5'd10, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{16'h0001, 5'd0,  5'd0,  5'd1,  1'b1, 1'b1, 1'b0};
    vecs[8]  = '{16'h0000, 5'd16, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1};
    vecs[9]  = '{16'h8000, 5'd1,  5'd0,  5'd1,  1'b1, 1'b1, 1'b0};
    vecs[10] = '{16'h1248, 5'd16, 5'd16, 5'd4,  1'b0, 1'b0, 1'b1};
    vecs[11] = '{16'hFFFF, 5'd16, 5'd15, 5'd16, 1'b1, 1'b1, 1'b0};

    // Reset values, observed while reset is held.
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_flags", int'({above_hi, below_lo}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transactions.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].d, vecs[i].hi, vecs[i].lo);
      collect($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].act, vecs[i].ab, vecs[i].be);
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: active is 1 here; 8 lies between thresholds so it holds.
    send(16'h00FF, 5'd20, 5'd0);
    collect("bp", 5'd8, 1'b1, 1'b0, 1'b0);
    data     = 16'hFFFF;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid_hold", int'(out_valid), 1);
      chk("bp_count_hold", int'(count), 8);
      chk("bp_in_ready_low", int'(in_ready), 0);
    end
    $display("txn bp_stall: out_valid=%0d count=%0d active=%0d", out_valid, count, active);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_out_valid", int'(out_valid), 0);
    chk("bp_idle_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    collect("bp_next", 5'd16, 1'b1, 1'b0, 1'b0);
    release_result("bp_next");

    // Asynchronous reset in the middle of a count.
    send(16'hAAAA, 5'd10, 5'd4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_active", int'(active), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    $display("txn arst: count=%0d out_valid=%0d active=%0d in_ready=%0d",
             count, out_valid, active, in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'hAAAA, 5'd10, 5'd4);
    collect("arst_after", 5'd8, 1'b0, 1'b0, 1'b0);
    release_result("arst_after");

    // Thresholds only matter at the final beat: th_hi drops to 6 just before it.
    send(16'h00FF, 5'd20, 5'd0);
    for (int c = 1; c < N; c++) begin
      @(negedge clk);
    end
    th_hi = 5'd6;
    @(negedge clk);
    chk("thchg_out_valid", int'(out_valid), 1);
    chk("thchg_count", int'(count), 8);
    chk("thchg_active", int'(active), 1);
    chk("thchg_above_hi", int'(above_hi), 1);
    $display("txn thchg: count=%0d active=%0d above_hi=%0d", count, active, above_hi);
    release_result("thchg");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
